// File: rtl/game_pkg.sv
// Shared game constants and the player state encoding.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int Y_OFS    = 480;
    localparam int COORD_W  = 11;

    localparam int BULLET_W = 20;
    localparam int BULLET_H = 60;
    localparam int PLAYER_W = 40;
    localparam int PLAYER_H = 40;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        INVUL     = 2'd1,
        GAME_OVER = 2'd2
    } player_state_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned rectangle intersection test.
// Strict compares: rectangles that only share an edge do not overlap.
// The coordinates are 11 bits wide and carry 10-bit positions, so the
// position-plus-size sums cannot wrap.
module rect_overlap
    import game_pkg::*;
#(
    parameter int A_W = PLAYER_W,
    parameter int A_H = PLAYER_H,
    parameter int B_W = BULLET_W,
    parameter int B_H = BULLET_H
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               overlap
);

    logic [COORD_W-1:0] a_right;
    logic [COORD_W-1:0] a_bottom;
    logic [COORD_W-1:0] b_right;
    logic [COORD_W-1:0] b_bottom;

    // Far edges of both rectangles, then the four separating-axis tests.
    always_comb begin
        a_right  = a_x + COORD_W'(A_W);
        a_bottom = a_y + COORD_W'(A_H);
        b_right  = b_x + COORD_W'(B_W);
        b_bottom = b_y + COORD_W'(B_H);
        overlap  = (b_x < a_right) && (a_x < b_right) &&
                   (b_y < a_bottom) && (a_y < b_bottom);
    end

endmodule

// File: rtl/player_hit_manager.sv
// Player hit manager: boss bullet vs. player hitbox once per frame, plus
// lives, post-hit invulnerability, sprite blink and sticky game-over.
module player_hit_manager
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int INVUL_FRAMES = 120,
    parameter int BLINK_LOG2   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] bb_x,
    input  logic [9:0] bb_y,
    input  logic       bullet_active,
    output logic       collide,
    output logic       hit_pulse,
    output logic [2:0] lives,
    output logic       invincible,
    output logic       player_visible,
    output logic       game_over
);

    player_state_t      state, state_n;
    logic [7:0]         inv_cnt, inv_cnt_n;
    logic [2:0]         lives_n;
    logic               collide_n;
    logic               hit_pulse_n;

    logic [COORD_W-1:0] bullet_row;
    logic               bullet_on_screen;
    logic               rect_hit;
    logic               overlap;
    logic               hit;

    // Bullet y arrives offset by Y_OFS; rows above the offset are off-screen.
    always_comb begin
        bullet_on_screen = (bb_y >= 10'(Y_OFS));
        bullet_row       = {1'b0, bb_y} - COORD_W'(Y_OFS);
    end

    rect_overlap #(
        .A_W (PLAYER_W),
        .A_H (PLAYER_H),
        .B_W (BULLET_W),
        .B_H (BULLET_H)
    ) u_overlap (
        .a_x     ({1'b0, player_x}),
        .a_y     ({1'b0, player_y}),
        .b_x     ({1'b0, bb_x}),
        .b_y     (bullet_row),
        .overlap (rect_hit)
    );

    assign overlap = rect_hit & bullet_on_screen;
    assign hit     = frame_tick & bullet_active & overlap & ~collide;

    // State, counters and flags; asynchronous reset returns everything to power-on values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALIVE;
            lives     <= 3'(LIVES_INIT);
            inv_cnt   <= 8'd0;
            collide   <= 1'b0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            lives     <= lives_n;
            inv_cnt   <= inv_cnt_n;
            collide   <= collide_n;
            hit_pulse <= hit_pulse_n;
        end
    end

    // Next-state logic: hit handling, invulnerability countdown, restart.
    always_comb begin
        state_n     = state;
        lives_n     = lives;
        inv_cnt_n   = inv_cnt;
        collide_n   = collide;
        hit_pulse_n = 1'b0;

        case (state)
            ALIVE: begin
                if (hit) begin
                    collide_n   = 1'b1;
                    hit_pulse_n = 1'b1;
                    lives_n     = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    if (lives <= 3'd1) begin
                        state_n = GAME_OVER;
                    end else begin
                        state_n   = INVUL;
                        inv_cnt_n = 8'(INVUL_FRAMES);
                    end
                end
            end
            INVUL: begin
                if (frame_tick) begin
                    // The bullet is absorbed but costs nothing while invulnerable.
                    if (hit) begin
                        collide_n = 1'b1;
                    end
                    inv_cnt_n = inv_cnt - 8'd1;
                    if (inv_cnt == 8'd1) begin
                        state_n = ALIVE;
                    end
                end
            end
            GAME_OVER: begin
                if (restart) begin
                    state_n   = ALIVE;
                    lives_n   = 3'(LIVES_INIT);
                    collide_n = 1'b0;
                    inv_cnt_n = 8'd0;
                end
            end
            default: begin
                state_n = ALIVE;
            end
        endcase

        // A bullet no longer in flight releases the collide handshake.
        if (!bullet_active) begin
            collide_n = 1'b0;
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        invincible = (state == INVUL);
        game_over  = (state == GAME_OVER);
        case (state)
            ALIVE:   player_visible = 1'b1;
            INVUL:   player_visible = ~inv_cnt[BLINK_LOG2];
            default: player_visible = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_player_hit_manager.sv
// Bench for player_hit_manager: directed scenarios followed by a random
// phase, all checked against a frame-level behavioural model.
module tb_player_hit_manager;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       restart;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] bb_x;
    logic [9:0] bb_y;
    logic       bullet_active;
    logic       collide;
    logic       hit_pulse;
    logic [2:0] lives;
    logic       invincible;
    logic       player_visible;
    logic       game_over;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: lives left, frames of invulnerability remaining,
    // game-over flag, bullet-consumed flag and "a life was just lost".
    int m_lives;
    int m_inv;
    bit m_go;
    bit m_col;
    bit m_hit;

    player_hit_manager dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .restart        (restart),
        .player_x       (player_x),
        .player_y       (player_y),
        .bb_x           (bb_x),
        .bb_y           (bb_y),
        .bullet_active  (bullet_active),
        .collide        (collide),
        .hit_pulse      (hit_pulse),
        .lives          (lives),
        .invincible     (invincible),
        .player_visible (player_visible),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    function automatic bit ref_overlap(int px, int py, int bx, int by_raw);
        int sy;
        if (by_raw < 480) return 1'b0;
        sy = by_raw - 480;
        return (bx < px + 40) && (px < bx + 20) && (sy < py + 40) && (py < sy + 60);
    endfunction

    task automatic model_reset();
        m_lives = 3;
        m_inv   = 0;
        m_go    = 1'b0;
        m_col   = 1'b0;
        m_hit   = 1'b0;
    endtask

    // One clock of game rules, applied to the inputs the DUT just sampled.
    task automatic model_step();
        bit ov;
        bit struck;
        ov     = ref_overlap(int'(player_x), int'(player_y), int'(bb_x), int'(bb_y));
        struck = frame_tick && bullet_active && ov && !m_col;
        m_hit  = 1'b0;
        if (m_go) begin
            if (restart) begin
                m_go    = 1'b0;
                m_lives = 3;
                m_col   = 1'b0;
                m_inv   = 0;
            end
        end else if (m_inv > 0) begin
            if (frame_tick) begin
                if (struck) m_col = 1'b1;
                m_inv = m_inv - 1;
            end
        end else if (struck) begin
            m_col   = 1'b1;
            m_hit   = 1'b1;
            m_lives = m_lives - 1;
            if (m_lives == 0) m_go = 1'b1;
            else m_inv = 120;
        end
        if (!bullet_active) m_col = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit exp_vis;
        // Blink: during invulnerability the sprite shows in alternating 8-frame bands.
        if (m_go)           exp_vis = 1'b0;
        else if (m_inv > 0) exp_vis = ((m_inv / 8) % 2) == 0;
        else                exp_vis = 1'b1;
        chk({tag, ".collide"},    32'(collide),        32'(m_col));
        chk({tag, ".hit_pulse"},  32'(hit_pulse),      32'(m_hit));
        chk({tag, ".lives"},      32'(lives),          32'(m_lives));
        chk({tag, ".invincible"}, 32'(invincible),     32'(m_inv > 0 && !m_go));
        chk({tag, ".visible"},    32'(player_visible), 32'(exp_vis));
        chk({tag, ".game_over"},  32'(game_over),      32'(m_go));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic frame(input string tag);
        frame_tick = 1'b1;
        cyc(tag);
        frame_tick = 1'b0;
        cyc(tag);
    endtask

    // Take the bullet out of flight for one clock and relaunch it.
    task automatic rearm(input string tag);
        bullet_active = 1'b0;
        cyc(tag);
        bullet_active = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        frame_tick    = 1'b0;
        restart       = 1'b0;
        player_x      = 10'd300;
        player_y      = 10'd400;
        bb_x          = 10'd310;
        bb_y          = 10'd870;
        bullet_active = 1'b0;
        model_reset();

        // Reset values
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc("idle");

        // Direct hit from ALIVE
        bullet_active = 1'b1;
        frame_tick    = 1'b1;
        cyc("t1_hit");
        chk("t1_lives", 32'(lives), 32'd2);
        chk("t1_pulse", 32'(hit_pulse), 32'd1);
        chk("t1_inv",   32'(invincible), 32'd1);
        frame_tick = 1'b0;
        cyc("t1_after");
        chk("t1_pulse_drop", 32'(hit_pulse), 32'd0);

        // Invulnerability window with a mid-window absorbed bullet
        for (int i = 1; i <= 120; i++) begin
            if (i == 60) rearm("t3_rearm");
            frame("t3_win");
            if (i == 60) chk("t3_absorb_col", 32'(collide), 32'd1);
            if (i == 119) chk("t3_still_inv", 32'(invincible), 32'd1);
        end
        chk("t3_inv_end",   32'(invincible), 32'd0);
        chk("t3_lives_kept", 32'(lives), 32'd2);

        // restart outside GAME_OVER is ignored
        restart = 1'b1;
        cyc("restart_ignored");
        restart = 1'b0;

        // Touching edge does not overlap; one pixel in does
        rearm("t2_rearm");
        bb_x = 10'd340;
        frame("t2_edge");
        chk("t2_edge_lives", 32'(lives), 32'd2);
        bb_x = 10'd339;
        frame("t2_inside");
        chk("t2_inside_lives", 32'(lives), 32'd1);

        // Last life lost after another window
        for (int i = 0; i < 120; i++) frame("t4_win");
        rearm("t4_rearm");
        frame("t4_final");
        chk("t4_go",    32'(game_over), 32'd1);
        chk("t4_lives", 32'(lives), 32'd0);
        chk("t4_vis",   32'(player_visible), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rearm("t4_dead_rearm");
            frame("t4_dead");
        end
        chk("t4_dead_lives", 32'(lives), 32'd0);

        // restart and frame_tick together: restart wins, no hit that frame
        frame_tick = 1'b1;
        restart    = 1'b1;
        cyc("t4_restart");
        frame_tick = 1'b0;
        restart    = 1'b0;
        chk("t4_restart_lives", 32'(lives), 32'd3);
        chk("t4_restart_go",    32'(game_over), 32'd0);
        cyc("t4_post");

        // collide follows bullet_active down; bullet above the offset never hits
        frame("t5_hit");
        bullet_active = 1'b0;
        cyc("t5_drop");
        chk("t5_col_clear", 32'(collide), 32'd0);
        for (int i = 0; i < 120; i++) frame("t5_win");
        bullet_active = 1'b1;
        bb_y = 10'd400;
        for (int i = 0; i < 3; i++) frame("t5_offscreen");
        chk("t5_lives", 32'(lives), 32'd2);

        // Asynchronous reset in the middle of invulnerability
        bb_y = 10'd870;
        frame("t6_hit");
        for (int i = 0; i < 70; i++) frame("t6_win");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(negedge clk);
        rst           = 1'b0;
        bullet_active = 1'b0;
        cyc("t6_release");

        // Random phase around the player
        for (int n = 0; n < 3000; n++) begin
            int px, py, bx, by;
            px = int'($urandom_range(0, 600));
            py = int'($urandom_range(0, 440));
            bx = px + int'($urandom_range(0, 80)) - 30;
            by = py + 480 + int'($urandom_range(0, 120)) - 70;
            if (bx < 0) bx = 0;
            player_x      = 10'(px);
            player_y      = 10'(py);
            bb_x          = 10'(bx);
            bb_y          = 10'(by);
            bullet_active = ($urandom_range(0, 9) != 0);
            frame_tick    = ($urandom_range(0, 2) == 0);
            restart       = ($urandom_range(0, 9) == 0);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
